// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, lookup in IF, update from MEM.
// Define BP_PERF_CNT_EN to add the branch/mispredict performance counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
`ifdef BP_PERF_CNT_EN
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts,
`endif
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic            valid_q [ENTRIES];
  logic            valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [TAG_W-1:0] tag_d  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [XLEN-1:0] tgt_d   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];
  logic [1:0]      ctr_d   [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Lookup reads only the registered table, so same-cycle writes appear next cycle.
  always_comb begin
    l_idx       = if_pc[IDX_W+1:2];
    l_tag       = if_pc[IDX_W+2 +: TAG_W];
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = l_hit && ctr_q[l_idx][1];
    pred_target = pred_taken ? tgt_q[l_idx] : if_pc + XLEN'(4);
  end

  always_comb begin
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  always_comb begin
    u_idx = upd_pc[IDX_W+1:2];
    u_tag = upd_pc[IDX_W+2 +: TAG_W];
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      tgt_d[i]   = tgt_q[i];
      ctr_d[i]   = ctr_q[i];
    end
    if (upd_valid) begin
      unique case (1'b1)
        u_hit && upd_is_jump: begin
          ctr_d[u_idx] = 2'd3;
          tgt_d[u_idx] = upd_target;
        end
        u_hit && !upd_is_jump: begin
          if (upd_taken) begin
            if (ctr_q[u_idx] != 2'd3) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
            tgt_d[u_idx] = upd_target;
          end else if (ctr_q[u_idx] != 2'd0) begin
            ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
          end
        end
        !u_hit && upd_taken: begin
          valid_d[u_idx] = 1'b1;
          tag_d[u_idx]   = u_tag;
          tgt_d[u_idx]   = upd_target;
          ctr_d[u_idx]   = upd_is_jump ? 2'd3 : 2'd2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        tgt_q[i]   <= tgt_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q + (upd_valid ? 32'd1 : 32'd0);
    mp_cnt_d = mp_cnt_q + (mispredict ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 16 entries, 8-bit tags).
// Index of 0x40 is 0 with tag 1; 0x80 aliases to index 0 with tag 2.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'h40;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic        upd_is_jump = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_is_jump(upd_is_jump),
    .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
`ifdef BP_PERF_CNT_EN
    .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts),
`endif
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic j, input logic [31:0] pc,
                     input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    upd_valid = 1'b1; upd_is_jump = j; upd_pc = pc;
    upd_taken = t; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg;
    #1;
  endtask

  task automatic no_upd();
    upd_valid = 1'b0; upd_is_jump = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    if_pc = 32'h40;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pt got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL rst_tgt got=%h exp=44", pred_target); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rst_mp got=%0b exp=0", mispredict); end
    #3 rst_n = 1'b1;
    tick();
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL post_rst got=%0b/%h exp=0/44", pred_taken, pred_target); end
  endtask

  task automatic test_cold_taken();
    upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL cold_mp got=%0b exp=1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL cold_redir got=%h exp=80", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_rbw got=%0b exp=0", pred_taken); end
    tick(); no_upd();
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++; $display("FAIL cold_alloc got=%0b/%h exp=1/80", pred_taken, pred_target); end
  endtask

  task automatic test_hysteresis();
    upd(1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL hys_mp got=%0b exp=1", mispredict); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL hys_redir got=%h exp=44", redirect_pc); end
    tick(); no_upd();
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL hys_ctr1 got=%0b/%h exp=0/44", pred_taken, pred_target); end
    upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    tick();
    upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL hys_ok_mp got=%0b exp=0", mispredict); end
    tick();
    upd(1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); no_upd();
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++; $display("FAIL hys_ctr2 got=%0b/%h exp=1/80", pred_taken, pred_target); end
    // A second not-taken from 2 drops below the taken threshold
    upd(1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); no_upd();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hys_ctr1b got=%0b exp=0", pred_taken); end
    upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    tick(); no_upd();
  endtask

  task automatic test_jump();
    upd(1'b1, 32'h10, 1'b1, 32'h200, 1'b0, 32'h14);
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL jmp_mp got=%0b/%h exp=1/200", mispredict, redirect_pc); end
    tick(); no_upd();
    if_pc = 32'h10; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL jmp_pred got=%0b/%h exp=1/200", pred_taken, pred_target); end
    upd(1'b1, 32'h10, 1'b1, 32'h200, 1'b1, 32'h200);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL jmp_ok got=%0b exp=0", mispredict); end
    upd(1'b1, 32'h10, 1'b1, 32'h200, 1'b1, 32'h204);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL jmp_badtgt got=%0b exp=1", mispredict); end
    no_upd();
  endtask

  task automatic test_same_cycle_alias();
    if_pc = 32'h40;
    upd(1'b0, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL rbw_old got=%h exp=80", pred_target); end
    tick(); no_upd();
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hC0) begin errors++; $display("FAIL rbw_new got=%0b/%h exp=1/c0", pred_taken, pred_target); end
    if_pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin errors++; $display("FAIL alias got=%0b/%h exp=0/84", pred_taken, pred_target); end
    upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick(); no_upd();
    if_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hC0) begin errors++; $display("FAIL nt_noalloc got=%0b/%h exp=1/c0", pred_taken, pred_target); end
  endtask

  task automatic test_wrap_idle();
    if_pc = 32'hFFFF_FFFC; #1;
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL wrap_if got=%h exp=0", pred_target); end
    upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (redirect_pc !== 32'h0 || mispredict !== 1'b0) begin errors++; $display("FAIL wrap_upd got=%h/%0b exp=0/0", redirect_pc, mispredict); end
    upd(1'b0, 32'h40, 1'b1, 32'h99, 1'b0, 32'h0);
    upd_valid = 1'b0; #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL idle_mp got=%0b exp=0", mispredict); end
    tick(); no_upd();
    if_pc = 32'h40; #1;
    checks++; if (pred_target !== 32'hC0) begin errors++; $display("FAIL idle_nowrite got=%h exp=c0", pred_target); end
  endtask

  task automatic test_async_reset();
    if_pc = 32'h40;
    upd(1'b0, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    rst_n = 1'b0; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL arst got=%0b/%h exp=0/44", pred_taken, pred_target); end
    no_upd();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL arst_mp got=%0b exp=0", mispredict); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL arst_clear got=%0b exp=0", pred_taken); end
  endtask

`ifdef BP_PERF_CNT_EN
  task automatic test_perf();
    checks++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin errors++; $display("FAIL perf_rst got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); end
    for (int i = 0; i < 10; i++) begin
      upd(1'b0, 32'h300, 1'b0, 32'h0, (i % 3 == 0 && i < 9), 32'h304);
      tick();
    end
    no_upd();
    tick();
    checks++; if (perf_branches !== 32'd10) begin errors++; $display("FAIL perf_br got=%0d exp=10", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd3) begin errors++; $display("FAIL perf_mp got=%0d exp=3", perf_mispredicts); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_jump();
    test_same_cycle_alias();
    test_wrap_idle();
    test_async_reset();
`ifdef BP_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
